mic_shift_unit: RTL and testbench

Parametrised, multi-cycle successor to the Mic-1 datapath shifter. It accepts an operand, shift mode and shift amount over a valid/ready handshake, and shifts by at most STEP bit positions per clock until the full amount is applied. It then holds the result until the consumer takes it. The block sits between the ALU output and the C bus, for microinstructions that need variable-distance shifts beyond the fixed SLL8/SRA1.

---
 rtl/mic_shift_unit_pkg.sv | 26 ++
 rtl/mic_shift_unit_shift_step.sv | 36 +++
 rtl/mic_shift_unit.sv | 128 ++++++++++++
 tb/tb_mic_shift_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mic_shift_unit_pkg.sv
// mic_shift_unit_pkg
// Shared definitions for the multi-cycle Mic-1 shifter: the shift mode
// encoding used on the request interface and the controller state type.
// The mode encoding keeps SRA=01 and SLL=10 so the field lines up with the
// existing shifter control bits in the microinstruction word.
package mic_shift_unit_pkg;

    typedef enum logic [1:0] {
        SHIFT_NONE = 2'b00,
        SHIFT_SRA  = 2'b01,
        SHIFT_SLL  = 2'b10,
        SHIFT_ROR  = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Width needed to hold a per-cycle shift count of 0..step inclusive.
    function automatic int step_count_width(input int step);
        return $clog2(step) + 1;
    endfunction

endpackage

// File: rtl/mic_shift_unit_shift_step.sv
// shift_step
// Purely combinational single-step shifter. Applies one shift of k bit
// positions (0..STEP) to the accumulator according to the mode.
// Ports:
//   acc     - current accumulator value
//   mode    - shift mode (NONE, SRA, SLL, ROR)
//   k       - number of positions to shift in this step
//   shifted - accumulator after the step
module shift_step
    import mic_shift_unit_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int STEP  = 8,
    localparam int KW   = step_count_width(STEP)
) (
    input  logic [NBITS-1:0] acc,
    input  shift_mode_t      mode,
    input  logic [KW-1:0]    k,
    output logic [NBITS-1:0] shifted
);

    // k never reaches NBITS while rotating (the remaining distance is at
    // most NBITS-1), and a left shift by exactly NBITS yields zero, which
    // makes k=0 rotate to acc unchanged.
    always_comb begin
        shifted = acc;
        unique case (mode)
            SHIFT_NONE: shifted = acc;
            SHIFT_SLL:  shifted = acc << k;
            SHIFT_SRA:  shifted = $unsigned($signed(acc) >>> k);
            SHIFT_ROR:  shifted = (acc >> k) | (acc << (NBITS - int'(k)));
            default:    shifted = acc;
        endcase
    end

endmodule

// File: rtl/mic_shift_unit.sv
// mic_shift_unit
// Multi-cycle variable-distance shifter between the ALU output and the C bus.
// A request (operand, mode, distance) is taken over a valid/ready handshake,
// shifted by at most STEP positions per clock, and the result is held until
// the consumer takes it.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   in_valid / in_ready   - request handshake (ready only while idle)
//   in_data, in_mode,
//   in_amt                - operand, shift mode and shift distance
//   out_valid / out_ready - result handshake
//   out_data              - result, zero whenever out_valid is low
//   busy                  - a request is being shifted or held
module mic_shift_unit
    import mic_shift_unit_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int STEP  = 8,
    parameter int AW    = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_data,
    input  shift_mode_t      in_mode,
    input  logic [AW-1:0]    in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_data,
    output logic             busy
);

    localparam int KW = step_count_width(STEP);

    state_t            state_q, state_d;
    logic [NBITS-1:0]  acc_q, acc_d;
    shift_mode_t       mode_q, mode_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic              in_ready_q, in_ready_d;

    logic [KW-1:0]     k;
    logic [NBITS-1:0]  step_result;

    // Distance applied this cycle: the remainder, capped at STEP.
    always_comb begin
        k = KW'(STEP);
        if (int'(rem_q) < STEP) begin
            k = KW'(rem_q);
        end
    end

    shift_step #(
        .NBITS (NBITS),
        .STEP  (STEP)
    ) u_shift_step (
        .acc     (acc_q),
        .mode    (mode_q),
        .k       (k),
        .shifted (step_result)
    );

    // Next-state logic. in_ready is registered from the next state so it
    // is a clean flop output and drops for the cycle following reset.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mode_d   = mode_q;
        rem_d    = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d  = in_data;
                    mode_d = in_mode;
                    rem_d  = (in_mode == SHIFT_NONE) ? '0 : in_amt;
                    if ((in_mode == SHIFT_NONE) || (in_amt == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = step_result;
                rem_d = rem_q - AW'(k);
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            mode_q     <= SHIFT_NONE;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            rem_q      <= rem_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Outputs depend only on registered state, never on in_* or out_ready.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_data  = (state_q == ST_DONE) ? acc_q : '0;
    end

endmodule

// File: tb/tb_mic_shift_unit.sv
// tb_mic_shift_unit
// Directed bench for mic_shift_unit with NBITS=32, STEP=8. Each step drives a
// request, measures the cycles until out_valid, and compares data, latency
// and handshake signals against hand-computed values.
module tb_mic_shift_unit;
    import mic_shift_unit_pkg::*;

    localparam int NBITS = 32;
    localparam int STEP  = 8;
    localparam int AW    = $clog2(NBITS);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_data;
    shift_mode_t      in_mode;
    logic [AW-1:0]    in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_data;
    logic             busy;

    int vectors;
    int miscompares;
    int lat;
    int busyCycles;

    mic_shift_unit #(
        .NBITS (NBITS),
        .STEP  (STEP),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts the vector and reports any difference.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one request for one edge.
    // Afterwards the request inputs are scrambled to show they are not used.
    task automatic startRequest(input logic [31:0] data, input shift_mode_t mode, input logic [AW-1:0] amt);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("ready_before_request", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        in_amt   = amt;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        in_mode  = SHIFT_SLL;
        in_amt   = 5'd3;
    endtask

    // Issue a request and count cycles (t+1 onwards) until out_valid.
    task automatic applyStimulus(input logic [31:0] data, input shift_mode_t mode, input logic [AW-1:0] amt);
        startRequest(data, mode, amt);
        lat        = 1;
        busyCycles = 0;
        while (!out_valid && lat < 64) begin
            if (busy) busyCycles++;
            tick();
            lat++;
        end
        if (busy) busyCycles++;
    endtask

    // Compare the held result and its latency, then (with out_ready high)
    // complete the handshake and confirm the block went idle.
    task automatic checkOutput(input string tag, input logic [31:0] expData, input int expLat, input bit finish);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, expData);
        check({tag, "_latency"}, 32'(lat), 32'(expLat));
        if (finish) begin
            tick();
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_mode     = SHIFT_NONE;
        in_amt      = '0;
        out_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic modes
        applyStimulus(32'hF0F0CDCD, SHIFT_SLL, 5'd8);
        checkOutput("sll8", 32'hF0CDCD00, 2, 1'b1);
        applyStimulus(32'hF0F0CDCD, SHIFT_SRA, 5'd1);
        checkOutput("sra1_neg", 32'hF87866E6, 2, 1'b1);
        applyStimulus(32'h00F0CDCD, SHIFT_SRA, 5'd1);
        checkOutput("sra1_pos", 32'h007866E6, 2, 1'b1);

        // Multi-step SRA with busy tracking
        applyStimulus(32'hF0F0CDCD, SHIFT_SRA, 5'd20);
        check("sra20_busy_cycles", 32'(busyCycles), 32'd4);
        checkOutput("sra20", 32'hFFFFFF0F, 4, 1'b1);

        applyStimulus(32'hF0F0CDCD, SHIFT_ROR, 5'd4);
        checkOutput("ror4", 32'hDF0F0CDC, 2, 1'b1);

        // Zero-distance paths
        applyStimulus(32'hF0F0CDCD, SHIFT_NONE, 5'd31);
        checkOutput("none31", 32'hF0F0CDCD, 1, 1'b1);
        applyStimulus(32'hF0F0CDCD, SHIFT_SLL, 5'd0);
        checkOutput("sll0", 32'hF0F0CDCD, 1, 1'b1);

        // Maximum distance
        applyStimulus(32'h80000000, SHIFT_SRA, 5'd31);
        checkOutput("sra31_neg", 32'hFFFFFFFF, 5, 1'b1);
        applyStimulus(32'hF0F0CDCD, SHIFT_ROR, 5'd31);
        checkOutput("ror31", 32'hE1E19B9B, 5, 1'b1);
        applyStimulus(32'hF0F0CDCD, SHIFT_SLL, 5'd31);
        checkOutput("sll31", 32'h80000000, 5, 1'b1);

        // Backpressure: result held, new request ignored until idle
        out_ready = 1'b0;
        applyStimulus(32'hF0F0CDCD, SHIFT_SLL, 5'd8);
        checkOutput("bp_first", 32'hF0CDCD00, 2, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        in_mode  = SHIFT_NONE;
        in_amt   = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, 32'hF0CDCD00);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_data", out_data, 32'h12345678);
        tick();
        check("bp_second_drop", 32'(out_valid), 32'd0);

        // Reset while shifting discards the result
        startRequest(32'h80000000, SHIFT_SRA, 5'd31);
        tick();
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_rst_no_pulse", 32'(out_valid), 32'd0);
        end
        applyStimulus(32'hF0F0CDCD, SHIFT_SLL, 5'd8);
        checkOutput("after_rst_sll8", 32'hF0CDCD00, 2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
